mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the accelerator memory request interface: accepts read/write
//  requests plus write beats, and returns read beats from an internal word-addressed SRAM.
//  Sits opposite the accelerator's memory initiator in standalone benches and host-less sims.
//  One request in flight at a time; bursts of len+1 words.
// PARAMETERS
//  MEM_LEN_BITS   8   width of mem_req_len (burst length minus one)
//  MEM_ADDR_BITS  64  width of mem_req_addr (word address)
//  MEM_DATA_BITS  64  data word width
//  DEPTH_BITS     10  SRAM depth = 2**DEPTH_BITS words
//  RD_LATENCY     2   cycles from read-request acceptance to first mem_rd_valid; legal range 1..15
// PORTS
//  clock           in   1              clock
//  reset           in   1              asynchronous, active-high reset
//  mem_req_valid   in   1              request strobe (single cycle; there is no request ready)
//  mem_req_opcode  in   1              0=read, 1=write
//  mem_req_len     in   MEM_LEN_BITS   beats-1
//  mem_req_addr    in   MEM_ADDR_BITS  first word address
//  mem_wr_valid    in   1              write beat strobe
//  mem_wr_bits     in   MEM_DATA_BITS  write beat data
//  mem_rd_valid    out  1              read beat valid
//  mem_rd_bits     out  MEM_DATA_BITS  read beat data
//  mem_rd_ready    in   1              initiator accepts read beat
//  err_proto       out  1              sticky: request while busy, or write beat outside WR_DATA
//  err_oob         out  1              sticky: a beat address >= 2**DEPTH_BITS
// BEHAVIOUR
//  Reset: state=IDLE; mem_rd_valid=0, mem_rd_bits=0, err_proto=0, err_oob=0. SRAM contents not reset.
//  States: IDLE, RD_WAIT, RD_DATA, WR_DATA.
//  IDLE: mem_req_valid latches opcode, addr, beat count = len+1. Read -> RD_WAIT, latency count
//   loaded with RD_LATENCY-1. Write -> WR_DATA.
//  RD_WAIT: count decrements; at 0 -> RD_DATA. Request accepted at cycle T gives mem_rd_valid=1
//   at T+RD_LATENCY. RD_LATENCY=1 goes straight from IDLE to RD_DATA.
//  RD_DATA: mem_rd_valid=1, mem_rd_bits=SRAM[addr]. Bits are stable while valid & ~ready.
//   On valid & ready: addr+1 and beat count-1. The next beat is valid the following cycle
//   (1 beat/cycle when ready is held high). Last beat handshake -> IDLE; mem_rd_valid=0 next cycle.
//  WR_DATA: each mem_wr_valid writes mem_wr_bits to SRAM[addr], addr+1, count-1.
//   Last beat -> IDLE. A new request is accepted in the cycle after the last beat of the
//   previous request.
//  Write-then-read of the same word: the read returns the new data (SRAM write occurs at the
//   beat edge, before any later request can be accepted).
//  Addressing: word index = mem_req_addr; beat address = start + beat number, 64-bit wrap.
//   Any beat address >= 2**DEPTH_BITS sets err_oob. Such a read beat returns 0 but still
//   handshakes normally; such a write beat is dropped.
//  Protocol errors set err_proto and are otherwise ignored, with no state change:
//   - mem_req_valid in any state other than IDLE;
//   - mem_wr_valid in any state other than WR_DATA.
//  Simultaneous mem_req_valid and mem_wr_valid in IDLE: the request is accepted, the beat is
//   ignored, and err_proto is set.
//  Reset mid-burst: immediate return to IDLE; the burst is abandoned; words already written
//   remain in the SRAM.
//  Sticky errors clear only on reset.
// CONFIGURATION
//  MEM_RESPONDER_STATS_EN defined: adds outputs stat_rd_beats[31:0] and stat_wr_beats[31:0].
//   They count completed read handshakes and accepted write beats, including out-of-bounds beats.
//   Both reset to 0, increment by 1 per beat, wrap at 2**32, and exclude ignored/error beats.
//  Not defined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then write len=0 addr=5 with beat 0xAB at T+1; read len=0 addr=5, ready=1 ->
//     mem_rd_valid at T'+2 with bits 0xAB; errors remain 0.
//  2. Write burst len=3 addr=16 data 1,2,3,4; read burst len=3, ready=1 -> 4 consecutive valid
//     cycles with 1,2,3,4, then valid=0.
//  3. Read len=1 with ready low for 3 cycles on beat 0 -> bits held constant and valid held
//     high; beat 1 follows the handshake by one cycle.
//  4. mem_req_valid during RD_WAIT, and mem_wr_valid in IDLE -> err_proto=1; the in-flight read
//     still returns correct data; SRAM is unchanged.
//  5. Read addr=2**DEPTH_BITS-1, len=1 -> beat 0 returns SRAM data, beat 1 returns 0, err_oob=1.
//  6. Assert reset mid write burst after 2 of 4 beats -> IDLE; a read of those 4 words shows
//     2 new and 2 old values. With MEM_RESPONDER_STATS_EN, the counters match the beats issued.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed SRAM responder for the accelerator memory request interface.
// Optional feature macro MEM_RESPONDER_STATS_EN adds stat_rd_beats / stat_wr_beats counters.
module mem_responder #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_BITS    = 10,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic                     mem_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_valid,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  input  logic                     mem_rd_ready,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [31:0]              stat_rd_beats,
  output logic [31:0]              stat_wr_beats,
`endif
  output logic                     err_proto,
  output logic                     err_oob
);

  localparam int CNT_W = MEM_LEN_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RD_DATA = 2'd2,
    S_WR_DATA = 2'd3
  } state_e;

  state_e                     state_q;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [MEM_ADDR_BITS-1:0]   addr_nxt_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [3:0]                 lat_q;
  logic                       rd_valid_q;
  logic [MEM_DATA_BITS-1:0]   rd_bits_q;
  logic                       err_proto_q;
  logic                       err_oob_q;
  logic                       last_beat_d;
  logic                       rd_hs_d;
  logic                       wr_beat_d;
  logic                       sram_we_d;
  logic [MEM_DATA_BITS-1:0]   sram_q [0:(1<<DEPTH_BITS)-1];

  function automatic logic addr_oob(input logic [MEM_ADDR_BITS-1:0] a);
    return (a >> DEPTH_BITS) != {MEM_ADDR_BITS{1'b0}};
  endfunction

  // Out-of-range beats read as zero rather than aliasing onto a real word.
  function automatic logic [MEM_DATA_BITS-1:0] read_word(input logic [MEM_ADDR_BITS-1:0] a);
    if (addr_oob(a)) begin
      return {MEM_DATA_BITS{1'b0}};
    end else begin
      return sram_q[a[DEPTH_BITS-1:0]];
    end
  endfunction

  // Beat bookkeeping and SRAM write enable.
  always_comb begin
    addr_nxt_d  = addr_q + MEM_ADDR_BITS'(1);
    last_beat_d = (cnt_q == CNT_W'(1));
    rd_hs_d     = (state_q == S_RD_DATA) && mem_rd_ready;
    wr_beat_d   = (state_q == S_WR_DATA) && mem_wr_valid;
    if (wr_beat_d && !addr_oob(addr_q)) begin
      sram_we_d = 1'b1;
    end else begin
      sram_we_d = 1'b0;
    end
  end

  // SRAM storage; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (sram_we_d) begin
      sram_q[addr_q[DEPTH_BITS-1:0]] <= mem_wr_bits;
    end
  end

  // Request/burst FSM with registered read port and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= {MEM_ADDR_BITS{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      lat_q       <= 4'd0;
      rd_valid_q  <= 1'b0;
      rd_bits_q   <= {MEM_DATA_BITS{1'b0}};
      err_proto_q <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      if ((mem_req_valid && state_q != S_IDLE) || (mem_wr_valid && state_q != S_WR_DATA)) begin
        err_proto_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (mem_req_valid) begin
            addr_q <= mem_req_addr;
            cnt_q  <= CNT_W'(mem_req_len) + CNT_W'(1);
            if (mem_req_opcode) begin
              state_q <= S_WR_DATA;
            end else if (RD_LATENCY == 1) begin
              state_q    <= S_RD_DATA;
              rd_valid_q <= 1'b1;
              rd_bits_q  <= read_word(mem_req_addr);
              if (addr_oob(mem_req_addr)) err_oob_q <= 1'b1;
            end else begin
              state_q <= S_RD_WAIT;
              lat_q   <= 4'(RD_LATENCY - 1);
            end
          end
        end
        S_RD_WAIT: begin
          if (lat_q == 4'd1) begin
            state_q    <= S_RD_DATA;
            rd_valid_q <= 1'b1;
            rd_bits_q  <= read_word(addr_q);
            if (addr_oob(addr_q)) err_oob_q <= 1'b1;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        S_RD_DATA: begin
          if (rd_hs_d) begin
            if (last_beat_d) begin
              state_q    <= S_IDLE;
              rd_valid_q <= 1'b0;
            end else begin
              addr_q    <= addr_nxt_d;
              cnt_q     <= cnt_q - CNT_W'(1);
              rd_bits_q <= read_word(addr_nxt_d);
              if (addr_oob(addr_nxt_d)) err_oob_q <= 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (wr_beat_d) begin
            if (addr_oob(addr_q)) err_oob_q <= 1'b1;
            addr_q <= addr_nxt_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (last_beat_d) state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;

  // Beat counters: completed read handshakes and accepted write beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_rd_q <= 32'd0;
      stat_wr_q <= 32'd0;
    end else begin
      if (rd_hs_d) stat_rd_q <= stat_rd_q + 32'd1;
      if (wr_beat_d) stat_wr_q <= stat_wr_q + 32'd1;
    end
  end

  assign stat_rd_beats = stat_rd_q;
  assign stat_wr_beats = stat_wr_q;
`endif

  assign mem_rd_valid = rd_valid_q;
  assign mem_rd_bits  = rd_bits_q;
  assign err_proto    = err_proto_q;
  assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed bursts against a word-level memory model.
module tb_mem_responder;

  localparam int          RD_LAT = 2;
  localparam logic [63:0] DEPTH  = 64'd1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_ready;
  logic        err_proto;
  logic        err_oob;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] stat_rd_beats;
  logic [31:0] stat_wr_beats;
`endif

  mem_responder #(
    .MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64), .DEPTH_BITS(10), .RD_LATENCY(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
`ifdef MEM_RESPONDER_STATS_EN
    .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
`endif
    .err_proto(err_proto), .err_oob(err_oob)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] mdl_mem [longint];
  logic [63:0] exp_q [$];
  logic        exp_proto;
  logic        exp_oob;
  int unsigned exp_rd_cnt;
  int unsigned exp_wr_cnt;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  function automatic logic [63:0] mdl_rd(input logic [63:0] a);
    if (a >= DEPTH) return 64'd0;
    if (!mdl_mem.exists(longint'(a))) return 64'd0;
    return mdl_mem[longint'(a)];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every valid read beat must carry the oldest outstanding expected word.
  always @(negedge clock) begin
    if (!reset && mem_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got beat 0x%0h, expected no beat", mem_rd_bits);
      end else begin
        check("rd_bits", mem_rd_bits, exp_q[0]);
        if (mem_rd_ready) begin
          void'(exp_q.pop_front());
          exp_rd_cnt++;
        end
      end
    end
  end

  task automatic do_write(input logic [63:0] a, input int n, input logic [63:0] base);
    logic [63:0] ba;
    mem_req_valid  = 1'b1;
    mem_req_opcode = 1'b1;
    mem_req_len    = 8'(n - 1);
    mem_req_addr   = a;
    tick();
    mem_req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      ba           = a + 64'(i);
      mem_wr_valid = 1'b1;
      mem_wr_bits  = base + 64'(i);
      if (ba < DEPTH) mdl_mem[longint'(ba)] = base + 64'(i);
      else exp_oob = 1'b1;
      exp_wr_cnt++;
      tick();
    end
    mem_wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    check("rd_valid_after_burst", {63'd0, mem_rd_valid}, 64'd0);
  endtask

  task automatic queue_read(input logic [63:0] a, input int n);
    logic [63:0] ba;
    for (int i = 0; i < n; i++) begin
      ba = a + 64'(i);
      exp_q.push_back(mdl_rd(ba));
      if (ba >= DEPTH) exp_oob = 1'b1;
    end
    mem_req_valid  = 1'b1;
    mem_req_opcode = 1'b0;
    mem_req_len    = 8'(n - 1);
    mem_req_addr   = a;
    tick();
    mem_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, input int n);
    queue_read(a, n);
    wait_drain(n + RD_LAT + 10);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_proto"}, {63'd0, err_proto}, {63'd0, exp_proto});
    check({tag, "_err_oob"}, {63'd0, err_oob}, {63'd0, exp_oob});
`ifdef MEM_RESPONDER_STATS_EN
    check({tag, "_stat_rd"}, {32'd0, stat_rd_beats}, {32'd0, exp_rd_cnt});
    check({tag, "_stat_wr"}, {32'd0, stat_wr_beats}, {32'd0, exp_wr_cnt});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = 8'd0;
    mem_req_addr   = 64'd0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = 64'd0;
    mem_rd_ready   = 1'b1;
    exp_proto      = 1'b0;
    exp_oob        = 1'b0;
    exp_rd_cnt     = 0;
    exp_wr_cnt     = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rd_valid", {63'd0, mem_rd_valid}, 64'd0);
    check("reset_rd_bits", mem_rd_bits, 64'd0);
    check_flags("reset");
    reset = 1'b0;
    tick();

    // Single-word write then read; first beat appears RD_LAT cycles after the request.
    do_write(64'd5, 1, 64'hAB);
    queue_read(64'd5, 1);
    check("t1_wait_cycle", {63'd0, mem_rd_valid}, 64'd0);
    tick();
    check("t1_valid", {63'd0, mem_rd_valid}, 64'd1);
    check("t1_bits", mem_rd_bits, 64'hAB);
    tick();
    check("t1_valid_drop", {63'd0, mem_rd_valid}, 64'd0);
    check_flags("t1");

    // Four-beat write and read back.
    do_write(64'd16, 4, 64'd1);
    check("t2_model_pin", mdl_rd(64'd19), 64'd4);
    do_read(64'd16, 4);
    check_flags("t2");

    // Backpressure on beat 0 for three cycles.
    mem_rd_ready = 1'b0;
    queue_read(64'd16, 2);
    k = 0;
    while (!mem_rd_valid && k < 10) begin
      tick();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", {63'd0, mem_rd_valid}, 64'd1);
      check("t3_hold_bits", mem_rd_bits, 64'd1);
      tick();
    end
    mem_rd_ready = 1'b1;
    tick();
    check("t3_beat1_valid", {63'd0, mem_rd_valid}, 64'd1);
    check("t3_beat1_bits", mem_rd_bits, 64'd2);
    wait_drain(5);
    check_flags("t3");

    // Protocol errors: request during RD_WAIT, stray beat in IDLE, request+beat together.
    do_write(64'd40, 1, 64'h55);
    queue_read(64'd40, 1);
    mem_req_valid  = 1'b1;
    mem_req_opcode = 1'b1;
    mem_req_addr   = 64'd40;
    exp_proto      = 1'b1;
    tick();
    mem_req_valid = 1'b0;
    wait_drain(10);
    mem_wr_valid = 1'b1;
    mem_wr_bits  = 64'hDEAD;
    tick();
    mem_wr_valid = 1'b0;
    do_read(64'd40, 1);
    mem_req_valid  = 1'b1;
    mem_req_opcode = 1'b1;
    mem_req_len    = 8'd0;
    mem_req_addr   = 64'd41;
    mem_wr_valid   = 1'b1;
    mem_wr_bits    = 64'hBAD;
    tick();
    mem_req_valid = 1'b0;
    mem_wr_bits   = 64'h66;
    mdl_mem[41]   = 64'h66;
    exp_wr_cnt++;
    tick();
    mem_wr_valid = 1'b0;
    do_read(64'd41, 1);
    check("t4_model_pin", mdl_rd(64'd41), 64'h66);
    check_flags("t4");

    // Top-of-memory and out-of-range beats, including 64-bit address wrap.
    do_write(64'd1023, 1, 64'h77);
    do_write(64'd0, 1, 64'h99);
    check("t5_oob_clear_before", {63'd0, err_oob}, 64'd0);
    do_read(64'd1023, 2);
    check_flags("t5a");
    do_write(64'd1024, 1, 64'h11);
    do_read(64'd0, 1);
    do_read(64'hFFFF_FFFF_FFFF_FFFF, 2);
    check_flags("t5b");

    // Reset after two of four write beats: first two words new, last two old.
    do_write(64'd100, 4, 64'h10);
    mem_req_valid  = 1'b1;
    mem_req_opcode = 1'b1;
    mem_req_len    = 8'd3;
    mem_req_addr   = 64'd100;
    tick();
    mem_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_wr_valid = 1'b1;
      mem_wr_bits  = 64'h20 + 64'(i);
      mdl_mem[100 + i] = 64'h20 + 64'(i);
      tick();
    end
    mem_wr_valid = 1'b0;
    reset        = 1'b1;
    exp_proto    = 1'b0;
    exp_oob      = 1'b0;
    exp_rd_cnt   = 0;
    exp_wr_cnt   = 0;
    tick();
    reset = 1'b0;
    tick();
    check_flags("t6_reset");
    check("t6_model_pin", mdl_rd(64'd102), 64'h12);
    do_read(64'd100, 4);
    check_flags("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
